pdm_adc_decimator: RTL and testbench
====================================

Name: pdm_adc_decimator

Overview:
- Receive-side counterpart of the pdm_dac: turns a 1-bit pulse-density stream back into DATA_BITS-wide unsigned PCM samples.
- Uses a 3rd-order CIC (cascaded integrator-comb) decimator with decimation R = 2^DECIM_LOG2.
- Used for loopback verification of the synth output path (pdm_dac dout -> this din) and for sampling external PDM sources such as MEMS mics.
- Runs in the 16 MHz system clock domain; bit_en qualifies input bits.

Parameters:
- DATA_BITS, 12, output sample width; must satisfy DATA_BITS <= 3*DECIM_LOG2.
- DECIM_LOG2, 6, log2 of decimation ratio R; legal range 4..10; default gives R = 64.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- din  in  1  PDM bit; 1 = +full-scale density, 0 = zero.
- bit_en  in  1  din is sampled only on cycles where bit_en = 1; tie high for one bit per clk.
- dout  out  DATA_BITS  decoded unsigned sample; holds its value between strobes.
- dout_valid  out  1  single-cycle strobe marking a new dout.

Behaviour:
- One clock; reset is synchronous and active-low. rst_n low at a rising edge clears all of the following:
  - the three integrators and three comb delay registers
  - the snapshot register and the decimation counter
  - the warm-up counter, dout and dout_valid
- Reset values: dout = 0, dout_valid = 0. Reset asserted mid-window discards the partial window; the next window starts at the first bit_en after release.
- Internal width W = 3*DECIM_LOG2 + 1. All integrator and comb arithmetic is unsigned modulo 2^W. Wrap-around is intentional and must not be saturated.
- On a cycle with bit_en = 1:
  - I1 += din (zero-extended); I2 += I1; I3 += I2, each using the registered pre-edge values.
  - dcnt increments modulo R.
- On a cycle with bit_en = 0: integrators and dcnt hold.
- Decimation strobe: a cycle with bit_en = 1 and dcnt = R-1. At the following edge, snap <= I3 (this value includes the completing bit).
- Comb stage, one edge after snap loads:
  - C1 = snap - D1; C2 = C1 - D2; C3 = C2 - D3 (combinational).
  - D1 <= snap, D2 <= C1, D3 <= C2; result register res <= C3.
- Output stage, one further edge:
  - if res[W-1] = 1 (value 2^(W-1), i.e. an all-ones window), dout <= all ones (saturate);
  - otherwise dout <= res[W-2 : W-1-DATA_BITS] (truncate, no rounding).
  - dout_valid = 1 for exactly that cycle.
- Latency: dout_valid asserts 3 rising edges after the edge that samples the completing bit_en. The pipeline advances regardless of bit_en.
- Warm-up: the first 3 decimated results after reset are not emitted. dout_valid stays 0 and dout stays 0 during warm-up. The warm-up counter saturates at 3.
- Minimum strobe spacing is R cycles, which exceeds the pipeline depth, so stages never collide.
- Back-to-back bit_en (tied high) and sparse or irregular bit_en must give identical dout sequences; only timing differs.
- DC gain is R^3 = 2^(W-1). Steady density p yields dout ~= p * 2^DATA_BITS, clipped at 2^DATA_BITS - 1.

Decomposition:
- Package pdm_pkg:
  - CIC_ORDER = 3
  - function cic_width(decim_log2) = CIC_ORDER*decim_log2 + 1
  - local constant for warm-up count (= CIC_ORDER)
- One natural sub-module, cic_integrator: one W-bit enabled accumulator stage, instantiated 3 times in a generate loop.
- Comb stages, counters and output scaling stay inline in pdm_adc_decimator.

Test Plan:
- Default parameters, din = 0 constant, bit_en = 1:
  - no dout_valid for the first 3 windows;
  - 4th strobe arrives 3 edges after bit 256 is sampled with dout = 0, then one strobe every 64 cycles, all dout = 0.
- din = 1 constant, bit_en = 1 -> after warm-up every dout = 4095 (saturation path, res = 2^18).
- din alternating 1,0,1,0 -> after warm-up every dout = 2048 exactly (32 ones per window, res = 2^17).
- Loopback: pdm_dac (DATA_BITS 12) din = 1024 feeding din -> settled dout within 1024 +/- 8. Repeat at 3072 -> 3072 +/- 8.
- bit_en high 1 cycle in 3, din alternating -> same dout values (2048) as the dense case; dout_valid spacing 192 cycles; integrators hold on bit_en = 0 cycles.
- rst_n pulled low for 1 cycle mid-window after 10 valid outputs:
  - next edge: dout = 0, dout_valid = 0;
  - next 3 windows suppressed;
  - then correct values resume with no stale data.

Source files
------------

// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants and width helper for the PDM CIC decimator
// Contents:
//   CIC_ORDER     number of integrator/comb stage pairs
//   WARMUP_COUNT  decimated results discarded after reset while the combs fill
//   cic_width()   internal register width for a given log2 decimation ratio
package pdm_pkg;

    localparam int CIC_ORDER    = 3;
    localparam int WARMUP_COUNT = CIC_ORDER;

    // Bit growth of an order-N CIC is N*log2(R); the extra bit holds the
    // full-scale value R^N = 2^(W-1) so an all-ones window is distinguishable.
    function automatic int cic_width(input int decim_log2);
        return CIC_ORDER * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// rtl/cic_integrator.sv - one enabled modulo-2^W accumulator stage of the CIC
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset, clears the accumulator
//   en_i   in   accumulate on this edge
//   in_i   in   W-bit addend (previous stage output or zero-extended bit)
//   acc_o  out  registered accumulator value
module cic_integrator #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;

    // Wrap-around is intended: the combs recover the correct difference
    // as long as W covers the full bit growth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + in_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pdm_adc_decimator.sv
// rtl/pdm_adc_decimator.sv - 3rd-order CIC decimator turning a PDM bit stream into unsigned PCM
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   rst_n       in   synchronous active-low reset
//   din         in   PDM bit (1 = full-scale density)
//   bit_en      in   din is consumed only when high
//   dout        out  DATA_BITS unsigned sample, held between strobes
//   dout_valid  out  one-cycle strobe marking a new dout
// Pipeline: completing bit sampled at edge E0, snapshot at E1, comb result
// at E2, dout/dout_valid at E3. The first WARMUP_COUNT results are dropped.
module pdm_adc_decimator
    import pdm_pkg::*;
#(
    parameter int DATA_BITS  = 12,
    parameter int DECIM_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 bit_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid
);

    localparam int W = cic_width(DECIM_LOG2);
    localparam logic [1:0] WARM_MAX = 2'(WARMUP_COUNT);

    // Integrator chain
    logic [CIC_ORDER-1:0][W-1:0] integ_in;
    logic [CIC_ORDER-1:0][W-1:0] integ_out;

    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_integ
        if (k == 0) begin : g_first
            assign integ_in[k] = {{(W-1){1'b0}}, din};
        end else begin : g_next
            assign integ_in[k] = integ_out[k-1];
        end

        cic_integrator #(.W(W)) u_integ (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (bit_en),
            .in_i  (integ_in[k]),
            .acc_o (integ_out[k])
        );
    end

    // Decimation counter and snapshot
    logic [DECIM_LOG2-1:0] dcnt_q;
    logic                  strobe_d;
    logic                  strobe_q;
    logic                  snap_vld_q;
    logic [W-1:0]          snap_q;

    assign strobe_d = bit_en && (dcnt_q == '1);

    // The snapshot is taken one edge after the completing bit so that the
    // last integrator already reflects the edge that consumed that bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dcnt_q     <= '0;
            strobe_q   <= 1'b0;
            snap_vld_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            if (bit_en) begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            strobe_q   <= strobe_d;
            snap_vld_q <= strobe_q;
            if (strobe_q) begin
                snap_q <= integ_out[CIC_ORDER-1];
            end
        end
    end

    // Comb chain, runs once per decimated sample
    logic [W-1:0] d1_q, d2_q, d3_q;
    logic [W-1:0] c1_d, c2_d, c3_d;
    logic [W-1:0] res_q;
    logic         res_vld_q;

    always_comb begin
        c1_d = snap_q - d1_q;
        c2_d = c1_d - d2_q;
        c3_d = c2_d - d3_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= snap_vld_q;
            if (snap_vld_q) begin
                d1_q  <= snap_q;
                d2_q  <= c1_d;
                d3_q  <= c2_d;
                res_q <= c3_d;
            end
        end
    end

    // Output scaling: top bit set only for an all-ones window (2^(W-1)),
    // which would overflow DATA_BITS, so clip it to full scale.
    logic [DATA_BITS-1:0] dout_d;
    logic [DATA_BITS-1:0] dout_q;
    logic                 dout_valid_q;
    logic [1:0]           warm_q;

    always_comb begin
        dout_d = DATA_BITS'(res_q >> (W - 1 - DATA_BITS));
        if (res_q[W-1]) begin
            dout_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            warm_q       <= '0;
        end else begin
            dout_valid_q <= 1'b0;
            if (res_vld_q) begin
                if (warm_q < WARM_MAX) begin
                    warm_q <= warm_q + 1'b1;
                end else begin
                    dout_q       <= dout_d;
                    dout_valid_q <= 1'b1;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_pdm_adc_decimator.sv
// tb/tb_pdm_adc_decimator.sv - directed self-checking bench for pdm_adc_decimator
module tb_pdm_adc_decimator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        bit_en;
    logic [11:0] dout;
    logic        dout_valid;

    int checks = 0;
    int errors = 0;

    // Stimulus source state: 0 = const 0, 1 = const 1, 2 = alternating, 3 = DAC model
    int          din_mode;
    int          en_period;
    int          en_phase;
    logic        alt_bit;
    logic [11:0] dac_acc;
    logic [11:0] dac_val;
    int          n;

    always #5 clk = ~clk;

    pdm_adc_decimator #(.DATA_BITS(12), .DECIM_LOG2(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic next_din();
        logic [12:0] sum;
        sum = {1'b0, dac_acc} + {1'b0, dac_val};
        case (din_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return alt_bit;
            default: return sum[12];
        endcase
    endfunction

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic tick();
        logic [12:0] sum;
        bit_en = (en_phase == 0);
        din    = next_din();
        @(posedge clk);
        #1;
        if (bit_en) begin
            alt_bit = ~alt_bit;
            sum     = {1'b0, dac_acc} + {1'b0, dac_val};
            dac_acc = sum[11:0];
        end
        en_phase = (en_phase + 1 == en_period) ? 0 : en_phase + 1;
    endtask

    // One reset edge, then restart the stimulus source in the given mode.
    task automatic restart(input int mode, input int period, input logic [11:0] v);
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        din_mode  = mode;
        en_period = period;
        en_phase  = 0;
        alt_bit   = 1'b1;
        dac_acc   = '0;
        dac_val   = v;
    endtask

    // Ticks until dout_valid is seen; returns the tick count (budget on timeout).
    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget) begin
            tick();
            cnt++;
            if (dout_valid) break;
        end
        if (!dout_valid) begin
            checks++;
            errors++;
            $error("FAIL wait_valid_timeout observed no strobe expected strobe within %0d", budget);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 1'b0;
        bit_en    = 1'b0;
        din_mode  = 0;
        en_period = 1;
        en_phase  = 0;
        alt_bit   = 1'b1;
        dac_acc   = '0;
        dac_val   = '0;

        // Reset state and all-zero input
        restart(0, 1, 12'd0);
        check("reset_dout", int'(dout), 0);
        check("reset_valid", int'(dout_valid), 0);
        wait_valid(400, n);
        check("zero_first_latency", n, 259);
        check("zero_dout", int'(dout), 0);
        tick();
        check("zero_valid_single", int'(dout_valid), 0);
        wait_valid(100, n);
        check("zero_spacing", n, 63);
        check("zero_dout2", int'(dout), 0);

        // All-ones input saturates
        restart(1, 1, 12'd0);
        wait_valid(400, n);
        check("ones_first_latency", n, 259);
        check("ones_dout", int'(dout), 4095);
        wait_valid(100, n);
        check("ones_spacing", n, 64);
        check("ones_dout2", int'(dout), 4095);

        // Alternating input gives exactly half scale
        restart(2, 1, 12'd0);
        wait_valid(400, n);
        check("alt_first_latency", n, 259);
        check("alt_dout", int'(dout), 2048);
        tick();
        check("alt_valid_single", int'(dout_valid), 0);
        check("alt_dout_hold", int'(dout), 2048);
        wait_valid(100, n);
        check("alt_spacing", n, 63);
        check("alt_dout2", int'(dout), 2048);

        // Loopback from a first-order sigma-delta DAC model
        restart(3, 1, 12'd1024);
        wait_valid(400, n);
        check("dac1024_latency", n, 259);
        check("dac1024_range", int'(dout >= 12'd1016 && dout <= 12'd1032), 1);
        wait_valid(100, n);
        check("dac1024_range2", int'(dout >= 12'd1016 && dout <= 12'd1032), 1);
        restart(3, 1, 12'd3072);
        wait_valid(400, n);
        check("dac3072_range", int'(dout >= 12'd3064 && dout <= 12'd3080), 1);
        wait_valid(100, n);
        check("dac3072_range2", int'(dout >= 12'd3064 && dout <= 12'd3080), 1);

        // Sparse bit_en, one in three cycles
        restart(2, 3, 12'd0);
        wait_valid(1000, n);
        check("sparse_first_latency", n, 769);
        check("sparse_dout", int'(dout), 2048);
        wait_valid(300, n);
        check("sparse_spacing", n, 192);
        check("sparse_dout2", int'(dout), 2048);

        // Mid-window reset after ten outputs, then a different input
        restart(2, 1, 12'd0);
        wait_valid(400, n);
        check("pre_rst_latency", n, 259);
        check("pre_rst_dout0", int'(dout), 2048);
        for (int i = 1; i < 10; i++) begin
            wait_valid(100, n);
            check($sformatf("pre_rst_dout%0d", i), int'(dout), 2048);
        end
        repeat (20) tick();
        restart(1, 1, 12'd0);
        check("midrst_dout", int'(dout), 0);
        check("midrst_valid", int'(dout_valid), 0);
        wait_valid(400, n);
        check("post_rst_latency", n, 259);
        check("post_rst_dout", int'(dout), 4095);
        wait_valid(100, n);
        check("post_rst_spacing", n, 64);
        check("post_rst_dout2", int'(dout), 4095);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
